// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD adder/subtractor.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction
endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD add/subtract cell; chains through cin/cout.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       sub,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout,
  output logic       bad
);
  bcd_digit_t b_eff;
  logic [4:0] bin_sum;

  always_comb begin
    b_eff   = sub ? nines_comp(b) : b;
    bin_sum = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
    cout    = bin_sum[4] | (bin_sum[3:0] > BCD_MAX);
    // Out-of-range digits take the same correction path; no special casing.
    s       = cout ? bin_sum[3:0] + BCD_CORR : bin_sum[3:0];
    bad     = (a > BCD_MAX) | (b > BCD_MAX);
  end
endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD add/sub, LANES digits per clock, LS group first.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int LANES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] s,
  output logic                c,
  output logic                bad_digit
);
  localparam int STEPS = DIGITS / LANES;
  localparam int W     = 4 * DIGITS;
  localparam int GW    = 4 * LANES;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (DIGITS < 1 || LANES < 1 || (DIGITS % LANES) != 0) begin : g_param_chk
    $error("bcd_serial_addsub: DIGITS must be >= 1 and a multiple of LANES");
  end

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q, s_q;
  logic             sub_q, carry_q, c_q, bad_q;
  logic [IDX_W-1:0] idx_q;
  logic             last, in_bad;
  logic [31:0]      base;

  logic [GW-1:0]    grp_a, grp_b, grp_s;
  logic [LANES:0]   chain;
  logic [LANES-1:0] grp_bad;

  assign last  = (idx_q == IDX_W'(STEPS - 1));
  assign base  = 32'(idx_q) * GW;
  assign grp_a = a_q[base +: GW];
  assign grp_b = b_q[base +: GW];
  assign chain[0] = carry_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bcd_digit_addsub u_cell (
      .a    (grp_a[4*i +: 4]),
      .b    (grp_b[4*i +: 4]),
      .sub  (sub_q),
      .cin  (chain[i]),
      .s    (grp_s[4*i +: 4]),
      .cout (chain[i+1]),
      .bad  (grp_bad[i])
    );
  end

  // Whole-operand digit check is done on the live inputs at acceptance.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      in_bad = in_bad | (a[4*i +: 4] > BCD_MAX) | (b[4*i +: 4] > BCD_MAX);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          sub_q   <= sub;
          carry_q <= sub;
          bad_q   <= in_bad;
          idx_q   <= '0;
        end
        RUN: begin
          s_q[base +: GW] <= grp_s;
          carry_q         <= chain[LANES];
          idx_q           <= idx_q + 1'b1;
          bad_q           <= bad_q | (|grp_bad);
          if (last) c_q <= chain[LANES];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c         = c_q;
  assign bad_digit = bad_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: DIGITS=4 with LANES=1,2,4 instances.
module tb_bcd_serial_addsub;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic sub_in = 1'b0;
  logic [2:0] iv = '0, ir, ov, orr = '0, cc, bd;
  logic [2:0][15:0] ss;

  int n_chk = 0;
  int n_fail = 0;
  vec_t sb_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_serial_addsub #(.DIGITS(4), .LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (a_in),
      .b         (b_in),
      .sub       (sub_in),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .s         (ss[g]),
      .c         (cc[g]),
      .bad_digit (bd[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request on instance w and push its expectation to the scoreboard.
  task automatic send(input int w, input vec_t v);
    int n;
    @(negedge clk);
    a_in = v.a; b_in = v.b; sub_in = v.sub; iv[w] = 1'b1;
    sb_q.push_back(v);
    n = 0;
    while (!ir[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1;
    iv[w] = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom); sub_in = 1'($urandom);
  endtask

  task automatic wait_out(input int w, input int steps);
    int m;
    m = 0;
    @(negedge clk);
    while (!ov[w] && m < 100) begin
      m++;
      @(negedge clk);
    end
    chk("latency", m, steps);
  endtask

  task automatic check_pop(input int w);
    vec_t e;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: got output with empty queue, required pending entry");
      return;
    end
    e = sb_q.pop_front();
    if (!e.bad) begin
      chk("s", ss[w], e.s);
      chk("c", cc[w], e.c);
    end
    chk("bad_digit", bd[w], e.bad);
  endtask

  task automatic consume(input int w);
    orr[w] = 1'b1;
    @(posedge clk);
    #1;
    orr[w] = 1'b0;
    @(negedge clk);
    chk("in_ready_after_done", ir[w], 1'b1);
    chk("out_valid_cleared", ov[w], 1'b0);
  endtask

  task automatic run(input int w, input vec_t v);
    send(w, v);
    wait_out(w, 4 >> w);
    check_pop(w);
    consume(w);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b1, 1'b0};
    vecs[3] = '{16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h4321, 16'h0999, 1'b1, 16'h3322, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", ir[0], 1'b1);
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_s", ss[0], 16'h0);
    chk("rst_c", cc[0], 1'b0);
    chk("rst_bad", bd[0], 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(0, vecs[i]);

    // Bad digit followed by a clean request clears the flag.
    run(0, vecs[6]);
    run(0, vecs[0]);

    // Ripple across wider lane groups.
    run(1, vecs[1]);
    run(2, vecs[1]);
    run(1, vecs[3]);
    run(2, vecs[2]);

    // Backpressure: result held, new requests ignored.
    send(0, vecs[0]);
    wait_out(0, 4);
    iv[0] = 1'b1; a_in = 16'h9999; b_in = 16'h9999; sub_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", ov[0], 1'b1);
      chk("hold_s", ss[0], 16'h6912);
      chk("hold_c", cc[0], 1'b0);
      chk("hold_in_ready", ir[0], 1'b0);
    end
    iv[0] = 1'b0;
    check_pop(0);
    consume(0);
    run(0, vecs[2]);

    // Reset two cycles into RUN.
    send(0, vecs[0]);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov[0], 1'b0);
    chk("midrst_s", ss[0], 16'h0);
    chk("midrst_in_ready", ir[0], 1'b1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    run(0, v);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
